// File: rtl/ppb_pkg.sv
// Shared definitions for the Playstation Parallel Bus address arbiter.
package ppb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2,
    ST_REJECT  = 2'd3
  } ppb_state_t;

  localparam logic [7:0] PPB_ADDR_PAD     = 8'h01;
  localparam logic [7:0] PPB_ADDR_MEMCARD = 8'h81;
  localparam logic [7:0] PPB_IDLE_REPLY   = 8'hFF;

endpackage

// File: rtl/ppb_downstream_gate.sv
// Per-device gate: packet-reset gating plus one-cycle command/strobe forwarding.
module ppb_downstream_gate (
  input  logic       clk,
  input  logic       i_bus_reset,
  input  logic       i_granted,
  input  logic       i_load,
  input  logic [7:0] i_command,
  input  logic       i_command_strobe,
  output logic       o_packet_reset,
  output logic [7:0] o_command,
  output logic       o_command_strobe
);

  logic [7:0] r_command;
  logic       r_command_strobe;

  assign o_packet_reset = i_bus_reset | ~i_granted;

  // Forward on the grant the arbiter is moving into, so the address byte
  // itself reaches the device one cycle after its strobe.
  always_ff @(posedge clk or posedge i_bus_reset) begin
    if (i_bus_reset) begin
      r_command        <= '0;
      r_command_strobe <= 1'b0;
    end else if (i_load) begin
      r_command        <= i_command;
      r_command_strobe <= i_command_strobe;
    end else begin
      r_command        <= '0;
      r_command_strobe <= 1'b0;
    end
  end

  assign o_command        = r_command;
  assign o_command_strobe = r_command_strobe;

endmodule

// File: rtl/ppb_address_arbiter.sv
// Shares one PPB device port between two device personalities by address.
module ppb_address_arbiter
  import ppb_pkg::*;
#(
  parameter logic [7:0] ADDR_A     = PPB_ADDR_PAD,
  parameter logic [7:0] ADDR_B     = PPB_ADDR_MEMCARD,
  parameter logic [7:0] IDLE_REPLY = PPB_IDLE_REPLY
) (
  input  logic       clk,
  input  logic       PPB_packet_reset,
  input  logic [7:0] PPB_command,
  input  logic       PPB_command_strobe,
  output logic       PPB_ack_strobe,
  output logic [7:0] PPB_reply,
  output logic       PPB_reply_en,
  input  logic       enable_a,
  input  logic       enable_b,
  output logic       a_packet_reset,
  output logic       b_packet_reset,
  output logic [7:0] a_command,
  output logic [7:0] b_command,
  output logic       a_command_strobe,
  output logic       b_command_strobe,
  input  logic       a_ack_strobe,
  input  logic       b_ack_strobe,
  input  logic [7:0] a_reply,
  input  logic [7:0] b_reply,
  input  logic       a_reply_en,
  input  logic       b_reply_en,
  output logic [1:0] grant,
  output logic [7:0] byte_count
);

  ppb_state_t r_state;
  ppb_state_t w_state_next;
  logic [7:0] r_byte_count;

  // Decide ownership on the first strobe of the packet; A wins address ties.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_IDLE && PPB_command_strobe) begin
      if (PPB_command == ADDR_A && enable_a)
        w_state_next = ST_GRANT_A;
      else if (PPB_command == ADDR_B && enable_b)
        w_state_next = ST_GRANT_B;
      else
        w_state_next = ST_REJECT;
    end
  end

  // State register, held until the packet ends.
  always_ff @(posedge clk or posedge PPB_packet_reset) begin
    if (PPB_packet_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  // Saturating count of command bytes in the current packet.
  always_ff @(posedge clk or posedge PPB_packet_reset) begin
    if (PPB_packet_reset)
      r_byte_count <= '0;
    else if (PPB_command_strobe && r_byte_count != '1)
      r_byte_count <= r_byte_count + 8'd1;
  end

  assign byte_count = r_byte_count;
  assign grant      = {r_state == ST_GRANT_B, r_state == ST_GRANT_A};

  ppb_downstream_gate u_gate_a (
    .clk              (clk),
    .i_bus_reset      (PPB_packet_reset),
    .i_granted        (r_state == ST_GRANT_A),
    .i_load           (w_state_next == ST_GRANT_A),
    .i_command        (PPB_command),
    .i_command_strobe (PPB_command_strobe),
    .o_packet_reset   (a_packet_reset),
    .o_command        (a_command),
    .o_command_strobe (a_command_strobe)
  );

  ppb_downstream_gate u_gate_b (
    .clk              (clk),
    .i_bus_reset      (PPB_packet_reset),
    .i_granted        (r_state == ST_GRANT_B),
    .i_load           (w_state_next == ST_GRANT_B),
    .i_command        (PPB_command),
    .i_command_strobe (PPB_command_strobe),
    .o_packet_reset   (b_packet_reset),
    .o_command        (b_command),
    .o_command_strobe (b_command_strobe)
  );

  // Zero-latency reply path from the granted device.
  always_comb begin
    PPB_reply    = IDLE_REPLY;
    PPB_reply_en = 1'b0;
    case (r_state)
      ST_GRANT_A: begin
        PPB_reply    = a_reply;
        PPB_reply_en = a_reply_en;
      end
      ST_GRANT_B: begin
        PPB_reply    = b_reply;
        PPB_reply_en = b_reply_en;
      end
      default: ;
    endcase
  end

  // Only the granted device may request ACK; a reset cycle drops any request.
  always_comb begin
    PPB_ack_strobe = 1'b0;
    if (!PPB_packet_reset)
      PPB_ack_strobe = (r_state == ST_GRANT_A && a_ack_strobe) ||
                       (r_state == ST_GRANT_B && b_ack_strobe);
  end

endmodule
